// File: rtl/div32_seq.sv
// div32_seq: sequential radix-2 restoring 32/32 divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV32_SIGNED_EN for two's-complement truncating division; default build is unsigned only.
module div32_seq #(
   parameter int    UUID = 0,
   parameter string NAME = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wi_32bit_dividend,
   input  logic [31:0] wi_32bit_divisor,
   input  logic        wi_1bit_valid,
   output logic        wo_1bit_ready,
   output logic [31:0] wo_32bit_quot,
   output logic [31:0] wo_32bit_rem,
   output logic        wo_1bit_valid,
   input  logic        wi_1bit_ready,
   output logic        wo_1bit_dbz
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state;
   logic [31:0] part_rem;
   logic [31:0] quo_sh;
   logic [31:0] dvsr;
   logic [4:0]  count;
   logic        dbz_pend;
   logic [31:0] quot_q;
   logic [31:0] rem_q;
   logic        dbz_q;

   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [32:0] shifted;
   logic [32:0] trial;
   logic [32:0] rem_next;
   logic [31:0] quo_next;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;

   localparam int unused_name_len = NAME.len();
   logic unused_bits;
   assign unused_bits = ^{UUID, rem_next[32]};

`ifdef DIV32_SIGNED_EN
   logic neg_quot;
   logic neg_rem;

   assign mag_a    = wi_32bit_dividend[31] ? (~wi_32bit_dividend + 32'd1) : wi_32bit_dividend;
   assign mag_b    = wi_32bit_divisor[31]  ? (~wi_32bit_divisor + 32'd1)  : wi_32bit_divisor;
   assign quot_fix = neg_quot ? (~quo_next + 32'd1) : quo_next;
   assign rem_fix  = neg_rem  ? (~rem_next[31:0] + 32'd1) : rem_next[31:0];
`else
   assign mag_a    = wi_32bit_dividend;
   assign mag_b    = wi_32bit_divisor;
   assign quot_fix = quo_next;
   assign rem_fix  = rem_next[31:0];
`endif

   // The stored remainder is always below the divisor, so the 33-bit R never needs its MSB between steps.
   assign shifted  = {part_rem, quo_sh[31]};
   assign trial    = shifted - {1'b0, dvsr};
   assign rem_next = trial[32] ? shifted : trial;
   assign quo_next = {quo_sh[30:0], ~trial[32]};

   assign wo_1bit_ready = (state == IDLE) & ~rst;
   assign wo_1bit_valid = (state == DONE);
   assign wo_32bit_quot = quot_q;
   assign wo_32bit_rem  = rem_q;
   assign wo_1bit_dbz   = dbz_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         part_rem <= '0;
         quo_sh   <= '0;
         dvsr     <= '0;
         count    <= '0;
         dbz_pend <= 1'b0;
         quot_q   <= '0;
         rem_q    <= '0;
         dbz_q    <= 1'b0;
`ifdef DIV32_SIGNED_EN
         neg_quot <= 1'b0;
         neg_rem  <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (wi_1bit_valid) begin
                  part_rem <= '0;
                  // A zero divisor keeps the raw dividend so it can be returned untouched as the remainder.
                  quo_sh   <= (wi_32bit_divisor == 32'd0) ? wi_32bit_dividend : mag_a;
                  dvsr     <= mag_b;
                  count    <= 5'd31;
                  dbz_pend <= (wi_32bit_divisor == 32'd0);
`ifdef DIV32_SIGNED_EN
                  neg_quot <= wi_32bit_dividend[31] ^ wi_32bit_divisor[31];
                  neg_rem  <= wi_32bit_dividend[31];
`endif
                  state    <= CALC;
               end
            end
            CALC: begin
               if (dbz_pend) begin
                  quot_q <= 32'hFFFF_FFFF;
                  rem_q  <= quo_sh;
                  dbz_q  <= 1'b1;
                  state  <= DONE;
               end else begin
                  part_rem <= rem_next[31:0];
                  quo_sh   <= quo_next;
                  count    <= count - 5'd1;
                  if (count == 5'd0) begin
                     quot_q <= quot_fix;
                     rem_q  <= rem_fix;
                     dbz_q  <= 1'b0;
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               if (wi_1bit_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq; expectations follow DIV32_SIGNED_EN when it is defined.
module tb_div32_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wi_dividend;
   logic [31:0] wi_divisor;
   logic        wi_valid;
   logic        wo_ready;
   logic [31:0] wo_quot;
   logic [31:0] wo_rem;
   logic        wo_valid;
   logic        wi_ready;
   logic        wo_dbz;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   div32_seq dut (
      .clk               (clk),
      .rst               (rst),
      .wi_32bit_dividend (wi_dividend),
      .wi_32bit_divisor  (wi_divisor),
      .wi_1bit_valid     (wi_valid),
      .wo_1bit_ready     (wo_ready),
      .wo_32bit_quot     (wo_quot),
      .wo_32bit_rem      (wo_rem),
      .wo_1bit_valid     (wo_valid),
      .wi_1bit_ready     (wi_ready),
      .wo_1bit_dbz       (wo_dbz)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz, input int elat);
      int n;
      check({tag, " ready_before"}, {31'd0, wo_ready}, 32'd1);
      wi_dividend = a;
      wi_divisor  = b;
      wi_valid    = 1'b1;
      tick;
      wi_valid = 1'b0;
      n = 0;
      while (!wo_valid && n < 100) begin
         tick;
         n++;
      end
      check({tag, " latency"}, n, elat);
      check({tag, " quot"}, wo_quot, eq);
      check({tag, " rem"}, wo_rem, er);
      check({tag, " dbz"}, {31'd0, wo_dbz}, {31'd0, edbz});
      check({tag, " ready_in_done"}, {31'd0, wo_ready}, 32'd0);
      if (wi_ready) begin
         tick;
         check({tag, " valid_after"}, {31'd0, wo_valid}, 32'd0);
         check({tag, " ready_after"}, {31'd0, wo_ready}, 32'd1);
      end
   endtask

   initial begin
      logic seen;
      rst         = 1'b1;
      wi_dividend = '0;
      wi_divisor  = '0;
      wi_valid    = 1'b0;
      wi_ready    = 1'b1;
      #1;
      check("rst ready", {31'd0, wo_ready}, 32'd0);
      check("rst valid", {31'd0, wo_valid}, 32'd0);
      check("rst quot", wo_quot, 32'd0);
      check("rst rem", wo_rem, 32'd0);
      check("rst dbz", {31'd0, wo_dbz}, 32'd0);
      repeat (3) tick;
      rst = 1'b0;
      #1;
      check("release ready", {31'd0, wo_ready}, 32'd1);
      check("release valid", {31'd0, wo_valid}, 32'd0);
      tick;

      run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
      run_op("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
`ifdef DIV32_SIGNED_EN
      run_op("5/max", 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd0, 1'b0, 32);
`else
      run_op("5/max", 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0, 32);
`endif
      run_op("1234/0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);
      run_op("0/5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 32);
`ifdef DIV32_SIGNED_EN
      run_op("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32);
      run_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32);
      run_op("-9/0", 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1, 1);
`else
      run_op("fff9/2", 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 32);
      run_op("min/max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32);
`endif

      // Backpressure: result must hold and new operands must be ignored.
      wi_ready = 1'b0;
      run_op("bp 1000/10", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 32);
      for (int i = 0; i < 10; i++) begin
         wi_dividend = 32'd77 + i;
         wi_divisor  = 32'd1;
         wi_valid    = (i % 2 == 0);
         tick;
         check("bp quot", wo_quot, 32'd100);
         check("bp rem", wo_rem, 32'd0);
         check("bp valid/ready", {30'd0, wo_valid, wo_ready}, 32'd2);
      end
      wi_valid = 1'b0;
      wi_ready = 1'b1;
      tick;
      check("bp accepted valid", {31'd0, wo_valid}, 32'd0);
      check("bp accepted ready", {31'd0, wo_ready}, 32'd1);
      check("bp quot kept", wo_quot, 32'd100);

      // Reset in the middle of a calculation.
      wi_dividend = 32'd50000;
      wi_divisor  = 32'd7;
      wi_valid    = 1'b1;
      tick;
      wi_valid = 1'b0;
      repeat (15) tick;
      check("mid calc valid", {31'd0, wo_valid}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("midrst ready", {31'd0, wo_ready}, 32'd0);
      check("midrst valid", {31'd0, wo_valid}, 32'd0);
      check("midrst quot", wo_quot, 32'd0);
      check("midrst rem", wo_rem, 32'd0);
      check("midrst dbz", {31'd0, wo_dbz}, 32'd0);
      tick;
      tick;
      rst = 1'b0;
      #1;
      check("midrst release ready", {31'd0, wo_ready}, 32'd1);
      seen = 1'b0;
      repeat (40) begin
         tick;
         if (wo_valid) seen = 1'b1;
      end
      check("no stale result", {31'd0, seen}, 32'd0);
      run_op("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
